legv8_alu_unit: RTL and testbench

64-bit LEGv8 execute-stage block combining ALU-control decode with the arithmetic/logic unit. It maps the main-control ALUOp and the 11-bit instruction opcode to a 4-bit ALU control code, applies the operation to two 64-bit operands, and registers the result and the flags. It sits between the register file/ALUSrc mux and the data-memory/MemtoReg path of the single-cycle datapath.

---
 rtl/legv8_alu_unit_pkg.sv | 65 ++++++
 rtl/legv8_alu_unit_decode.sv | 33 +++
 rtl/legv8_alu_unit.sv | 93 +++++++++
 tb/tb_legv8_alu_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_alu_unit_pkg.sv
// Shared definitions for the LEGv8 execute-stage ALU block: ALUOp encodings,
// R-type opcode constants, ALU control codes and the registered output bundle.
package legv8_alu_unit_pkg;

  localparam int DATA_W   = 64;
  localparam int OPCODE_W = 11;
  localparam int CTRL_W   = 4;

  // ALUOp as produced by the main control unit.
  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  // R-type opcodes, instruction[31:21].
  localparam logic [OPCODE_W-1:0] OPC_ADD = 11'b100_0101_1000;
  localparam logic [OPCODE_W-1:0] OPC_SUB = 11'b110_0101_1000;
  localparam logic [OPCODE_W-1:0] OPC_AND = 11'b100_0101_0000;
  localparam logic [OPCODE_W-1:0] OPC_ORR = 11'b101_0101_0000;
  localparam logic [OPCODE_W-1:0] OPC_EOR = 11'b110_0101_0000;
  localparam logic [OPCODE_W-1:0] OPC_LSL = 11'b110_1001_1011;
  localparam logic [OPCODE_W-1:0] OPC_LSR = 11'b110_1001_1010;

  // 4-bit ALU control codes. NOR is implemented by the datapath even though
  // the current decode never selects it.
  typedef enum logic [CTRL_W-1:0] {
    CTRL_AND     = 4'b0000,
    CTRL_ORR     = 4'b0001,
    CTRL_ADD     = 4'b0010,
    CTRL_EOR     = 4'b0011,
    CTRL_SUB     = 4'b0110,
    CTRL_PASS_B  = 4'b0111,
    CTRL_LSL     = 4'b1000,
    CTRL_LSR     = 4'b1001,
    CTRL_NOR     = 4'b1100,
    CTRL_ILLEGAL = 4'b1111
  } alu_ctrl_e;

  // Registered result and flags, kept together so one register captures all.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              negative;
    logic              carry;
    logic              overflow;
    logic              illegal;
  } alu_out_t;

  localparam alu_out_t ALU_OUT_RESET = '{
    result:   64'd0,
    zero:     1'b1,
    negative: 1'b0,
    carry:    1'b0,
    overflow: 1'b0,
    illegal:  1'b0
  };

  // True for the codes that route through the adder and produce carry/overflow.
  function automatic logic uses_adder(input logic [CTRL_W-1:0] code);
    return (code == CTRL_ADD) || (code == CTRL_SUB);
  endfunction

endpackage

// File: rtl/legv8_alu_unit_decode.sv
// ALU control decode: maps main-control ALUOp and the R-type opcode field to
// the 4-bit ALU control code. Purely combinational.
module alu_control_decode
  import legv8_alu_unit_pkg::*;
(
  input  logic [1:0]          alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl
);

  // Two-level lookup: ALUOp first, opcode only matters for R-type.
  always_comb begin
    ctrl = CTRL_ILLEGAL;
    case (alu_op)
      ALUOP_LDST: ctrl = CTRL_ADD;
      ALUOP_CBZ:  ctrl = CTRL_PASS_B;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: ctrl = CTRL_ADD;
          OPC_SUB: ctrl = CTRL_SUB;
          OPC_AND: ctrl = CTRL_AND;
          OPC_ORR: ctrl = CTRL_ORR;
          OPC_EOR: ctrl = CTRL_EOR;
          OPC_LSL: ctrl = CTRL_LSL;
          OPC_LSR: ctrl = CTRL_LSR;
          default: ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/legv8_alu_unit.sv
// LEGv8 execute-stage ALU: decodes the ALU control code, evaluates the
// operation on two 64-bit operands and registers result plus flags with a
// capture enable. The control code output stays combinational.
module legv8_alu_unit
  import legv8_alu_unit_pkg::*;
(
  input  logic                iCLK,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic [1:0]          iALUOp,
  input  logic [OPCODE_W-1:0] iOpcode,
  input  logic [DATA_W-1:0]   iOperandA,
  input  logic [DATA_W-1:0]   iOperandB,
  output logic [CTRL_W-1:0]   oControlSignal,
  output logic [DATA_W-1:0]   oResult,
  output logic                oZero,
  output logic                oNegative,
  output logic                oCarry,
  output logic                oOverflow,
  output logic                oIllegal
);

  logic [CTRL_W-1:0] ctrl;
  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] adder_b;
  logic [DATA_W:0]   sum;
  logic [5:0]        shamt;
  alu_out_t          nxt;
  alu_out_t          out_q;

  alu_control_decode u_decode (
    .alu_op (iALUOp),
    .opcode (iOpcode),
    .ctrl   (ctrl)
  );

  assign oControlSignal = ctrl;

  // Single shared adder: subtraction is A + ~B + 1, so carry-out reads as
  // not-borrow and overflow uses the inverted B sign that actually enters it.
  assign is_sub   = (ctrl == CTRL_SUB);
  assign is_arith = uses_adder(ctrl);
  assign adder_b  = is_sub ? ~iOperandB : iOperandB;
  assign sum      = {1'b0, iOperandA} + {1'b0, adder_b} + {{DATA_W{1'b0}}, is_sub};

  // Shift distance is B modulo 64; upper bits of B are ignored.
  assign shamt = iOperandB[5:0];

  // Next-state result and flags for the current control code.
  always_comb begin
    nxt = '0;
    case (ctrl)
      CTRL_AND:    nxt.result = iOperandA & iOperandB;
      CTRL_ORR:    nxt.result = iOperandA | iOperandB;
      CTRL_EOR:    nxt.result = iOperandA ^ iOperandB;
      CTRL_ADD:    nxt.result = sum[DATA_W-1:0];
      CTRL_SUB:    nxt.result = sum[DATA_W-1:0];
      CTRL_PASS_B: nxt.result = iOperandB;
      CTRL_NOR:    nxt.result = ~(iOperandA | iOperandB);
      CTRL_LSL:    nxt.result = iOperandA << shamt;
      CTRL_LSR:    nxt.result = iOperandA >> shamt;
      default: begin
        nxt.result  = '0;
        nxt.illegal = 1'b1;
      end
    endcase
    nxt.zero     = (nxt.result == '0);
    nxt.negative = nxt.result[DATA_W-1];
    if (is_arith) begin
      nxt.carry    = sum[DATA_W];
      nxt.overflow = (iOperandA[DATA_W-1] == adder_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != iOperandA[DATA_W-1]);
    end
  end

  // Output register: async reset wins over enable; hold when enable is low.
  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      out_q <= ALU_OUT_RESET;
    end else if (iEnable) begin
      out_q <= nxt;
    end
  end

  assign oResult   = out_q.result;
  assign oZero     = out_q.zero;
  assign oNegative = out_q.negative;
  assign oCarry    = out_q.carry;
  assign oOverflow = out_q.overflow;
  assign oIllegal  = out_q.illegal;

endmodule

// File: tb/tb_legv8_alu_unit.sv
// Bench for legv8_alu_unit: directed cases with literal expectations plus
// randomized traffic checked against a behavioural model every cycle.
module tb_legv8_alu_unit;

  localparam int W = 69;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [10:0] opc = 11'd0;
  logic [63:0] op_a = 64'd0;
  logic [63:0] op_b = 64'd0;

  logic [3:0]  ctrl_sig;
  logic [63:0] res;
  logic        z, n, c, v, ill;

  legv8_alu_unit dut (
    .iCLK           (clk),
    .iReset         (rst),
    .iEnable        (en),
    .iALUOp         (alu_op),
    .iOpcode        (opc),
    .iOperandA      (op_a),
    .iOperandB      (op_b),
    .oControlSignal (ctrl_sig),
    .oResult        (res),
    .oZero          (z),
    .oNegative      (n),
    .oCarry         (c),
    .oOverflow      (v),
    .oIllegal       (ill)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic         sb_on = 1'b0;

  localparam logic [W-1:0] RESET_EXP = {64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] model_code(input logic [1:0] op, input logic [10:0] o);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0111;
    if (op == 2'b11) return 4'b1111;
    case (o)
      11'b10001011000: return 4'b0010;
      11'b11001011000: return 4'b0110;
      11'b10001010000: return 4'b0000;
      11'b10101010000: return 4'b0001;
      11'b11001010000: return 4'b0011;
      11'b11010011011: return 4'b1000;
      11'b11010011010: return 4'b1001;
      default:         return 4'b1111;
    endcase
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [10:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [64:0] wide;
    logic [63:0] r;
    logic        cy, ov, il;
    int          sh;
    cy = 1'b0; ov = 1'b0; il = 1'b0; r = 64'd0;
    sh = int'(b % 64);
    case (model_code(op, o))
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0010: begin
        wide = {1'b0, a} + {1'b0, b};
        r  = wide[63:0];
        cy = wide[64];
        ov = (a[63] == b[63]) && (r[63] != a[63]);
      end
      4'b0110: begin
        r  = a - b;
        cy = (a >= b);
        ov = (a[63] != b[63]) && (r[63] != a[63]);
      end
      4'b0111: r = b;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      default: il = 1'b1;
    endcase
    return {r, (r == 64'd0), r[63], cy, ov, il};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] dut_out();
    return {res, z, n, c, v, ill};
  endfunction

  // Scoreboard: one expected entry per driven cycle, checked after the edge.
  always begin
    @(posedge clk);
    #1;
    if (sb_on && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("sb_out", 128'(dut_out()), 128'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] op, input logic [10:0] o,
                      input logic [63:0] a, input logic [63:0] b, input logic e);
    @(negedge clk);
    alu_op = op; opc = o; op_a = a; op_b = b; en = e;
    #1;
    chk("ctrl", 128'(ctrl_sig), 128'(model_code(op, o)));
    if (e) last_exp = model(op, o, a, b);
    exp_q.push_back(last_exp);
  endtask

  task automatic wait_out();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 130));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;
  localparam logic [10:0] EOR = 11'b11001010000;
  localparam logic [10:0] LSL = 11'b11010011011;
  localparam logic [10:0] LSR = 11'b11010011010;

  logic [10:0] legal_opc [7];

  // ---------------- main sequence ----------------
  initial begin
    legal_opc = '{ADD, SUB, AND, ORR, EOR, LSL, LSR};
    last_exp = RESET_EXP;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_out", 128'(dut_out()), 128'(RESET_EXP));
    @(negedge clk);
    rst = 1'b0;
    sb_on = 1'b1;

    // Put a nonzero value in the registers before the mid-cycle reset.
    step(2'b00, 11'd0, 64'd3, 64'd4, 1'b1);
    wait_out();
    chk("pre_rst_res", 128'(res), 128'(64'd7));

    // 1: asynchronous reset mid-cycle with enable high.
    sb_on = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_res", 128'(res), 128'(64'd0));
    chk("async_rst_zero", 128'(z), 128'(1'b1));
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    last_exp = RESET_EXP;
    sb_on = 1'b1;

    step(2'b00, 11'd0, 64'd100, 64'd8, 1'b1);
    chk("t1_ctrl", 128'(ctrl_sig), 128'(4'b0010));
    wait_out();
    chk("t1_res", 128'(res), 128'(64'd108));
    chk("t1_zero", 128'(z), 128'(1'b0));

    // 2: subtraction, equal operands then borrow.
    step(2'b10, SUB, 64'h5, 64'h5, 1'b1);
    chk("t2_ctrl", 128'(ctrl_sig), 128'(4'b0110));
    wait_out();
    chk("t2a_flags", 128'({res, z, c}), 128'({64'd0, 1'b1, 1'b1}));
    step(2'b10, SUB, 64'd0, 64'd1, 1'b1);
    wait_out();
    chk("t2b_flags", 128'({res, n, c}), 128'({64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}));

    // 3: addition overflow and carry.
    step(2'b10, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    wait_out();
    chk("t3a_ovf", 128'({res, v}), 128'({64'h8000_0000_0000_0000, 1'b1}));
    step(2'b10, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    wait_out();
    chk("t3b_carry", 128'({res, c, z}), 128'({64'd0, 1'b1, 1'b1}));

    // 4: logic ops and shift boundaries.
    step(2'b10, AND, 64'hF0F0, 64'h0FF0, 1'b1);
    wait_out();
    chk("t4_and", 128'(res), 128'(64'h00F0));
    step(2'b10, ORR, 64'hF0F0, 64'h0FF0, 1'b1);
    wait_out();
    chk("t4_orr", 128'(res), 128'(64'hFFF0));
    step(2'b10, EOR, 64'hF0F0, 64'h0FF0, 1'b1);
    wait_out();
    chk("t4_eor", 128'(res), 128'(64'hFF00));
    step(2'b10, LSL, 64'd1, 64'd63, 1'b1);
    wait_out();
    chk("t4_lsl63", 128'(res), 128'(64'h8000_0000_0000_0000));
    step(2'b10, LSR, 64'h8000_0000_0000_0000, 64'd64, 1'b1);
    wait_out();
    chk("t4_lsr64", 128'(res), 128'(64'h8000_0000_0000_0000));

    // 5: pass-B and illegal decode.
    step(2'b01, 11'd0, 64'd5, 64'd0, 1'b1);
    chk("t5_ctrl", 128'(ctrl_sig), 128'(4'b0111));
    wait_out();
    chk("t5_passb", 128'({res, z}), 128'({64'd0, 1'b1}));
    step(2'b10, 11'd0, 64'd5, 64'd9, 1'b1);
    chk("t5_ill_ctrl", 128'(ctrl_sig), 128'(4'b1111));
    wait_out();
    chk("t5_ill", 128'({res, ill}), 128'({64'd0, 1'b1}));
    step(2'b11, ADD, 64'd5, 64'd9, 1'b1);
    wait_out();
    chk("t5_rsvd", 128'(ill), 128'(1'b1));

    // 6: hold with enable low while inputs change.
    step(2'b10, ADD, 64'd10, 64'd20, 1'b1);
    wait_out();
    chk("t6_cap", 128'(res), 128'(64'd30));
    for (int i = 0; i < 3; i++) begin
      step(2'b10, (i == 0) ? SUB : (i == 1) ? LSL : EOR, rand64(), rand64(), 1'b0);
      wait_out();
      chk("t6_hold", 128'({res, ill}), 128'({64'd30, 1'b0}));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] o;
      if ($urandom_range(0, 3) == 0) o = 11'($urandom);
      else o = legal_opc[$urandom_range(0, 6)];
      step(2'($urandom_range(0, 3)), o, rand64(), rand64(), ($urandom_range(0, 4) != 0));
    end

    // Drain the last scoreboard entry.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("sb_drain", 128'(exp_q.size()), 128'(0));
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
